// File: rtl/aes_key_sched_ctrl.sv
// AES key schedule controller: walks an external expansion engine
// through NumRounds requests and buffers every round key for readback.
module aes_key_sched_ctrl #(
  parameter int NumRounds     = 10,
  parameter int TimeoutCycles = 15
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         start_i,
  input  logic [1:0]   op_i,
  input  logic [127:0] key_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         keys_valid_o,
  output logic         err_o,
  output logic         eng_clear_o,
  output logic         eng_en_o,
  output logic [1:0]   eng_op_o,
  output logic [3:0]   eng_round_o,
  output logic [127:0] eng_key_o,
  input  logic         eng_req_i,
  output logic         eng_ack_o,
  input  logic [127:0] eng_key_i,
  input  logic [3:0]   rd_idx_i,
  output logic [127:0] rd_data_o,
  output logic         rd_err_o
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StClear = 3'd1;
  localparam logic [2:0] StReq   = 3'd2;
  localparam logic [2:0] StDone  = 3'd3;
  localparam logic [2:0] StErr   = 3'd4;

  localparam int TW = $clog2(TimeoutCycles + 1);
  localparam logic [3:0]    LastIdx = 4'(NumRounds);
  localparam logic [TW-1:0] TmoMax  = TW'(TimeoutCycles);

  logic [2:0]    state_q, state_d;
  logic [3:0]    round_q, round_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [1:0]    op_q, op_d;
  logic          kv_q, kv_d;
  logic [127:0]  rk_q [NumRounds+1];
  logic [127:0]  rd_data_q;
  logic          rd_err_q;
  logic          rk0_we, rkn_we;
  logic [3:0]    round_inc;
  logic [TW-1:0] tmo_inc;
  logic          in_req;
  logic          rd_ok;

  assign round_inc = round_q + 4'd1;
  assign tmo_inc   = tmo_q + TW'(1);
  assign in_req    = (state_q == StReq);
  assign rd_ok     = (rd_idx_i <= LastIdx);

  // Next-state logic: start handling, engine handshake and timeout.
  always_comb begin
    state_d = state_q;
    round_d = round_q;
    tmo_d   = tmo_q;
    op_d    = op_q;
    kv_d    = kv_q;
    rk0_we  = 1'b0;
    rkn_we  = 1'b0;
    unique case (state_q)
      StIdle, StErr: begin
        if (start_i) begin
          rk0_we  = 1'b1;
          op_d    = op_i;
          round_d = 4'd0;
          tmo_d   = '0;
          kv_d    = 1'b0;
          state_d = StClear;
        end
      end
      StClear: state_d = StReq;
      StReq: begin
        if (eng_req_i) begin
          rkn_we = 1'b1;
          tmo_d  = '0;
          if (round_inc == LastIdx) begin
            kv_d    = 1'b1;
            state_d = StDone;
          end else begin
            round_d = round_inc;
          end
        end else begin
          tmo_d = tmo_inc;
          if (tmo_inc == TmoMax) state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      round_q <= 4'd0;
      tmo_q   <= '0;
      op_q    <= 2'd0;
      kv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      tmo_q   <= tmo_d;
      op_q    <= op_d;
      kv_q    <= kv_d;
    end
  end

  // Round-key buffer: initial key at start, engine keys on accept.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i <= NumRounds; i++) rk_q[i] <= '0;
    end else begin
      if (rk0_we) rk_q[0] <= key_i;
      if (rkn_we) rk_q[round_inc] <= eng_key_i;
    end
  end

  // Registered read port with out-of-range flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      rd_data_q <= rd_ok ? rk_q[rd_idx_i] : '0;
      rd_err_q  <= !rd_ok;
    end
  end

  assign busy_o       = (state_q == StClear) || in_req;
  assign done_o       = (state_q == StDone);
  assign keys_valid_o = kv_q;
  assign err_o        = (state_q == StErr);
  assign eng_clear_o  = (state_q == StClear);
  assign eng_en_o     = in_req;
  assign eng_op_o     = op_q;
  assign eng_round_o  = in_req ? round_q : 4'd0;
  assign eng_key_o    = in_req ? rk_q[round_q] : '0;
  assign eng_ack_o    = in_req && eng_req_i;
  assign rd_data_o    = rd_data_q;
  assign rd_err_o     = rd_err_q;

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 Parameter NumRounds, default 10: number of round keys generated after the initial key (AES-128).
REQ-002 Parameter TimeoutCycles, default 15: maximum cycles to wait for a single engine response.
REQ-003 Port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-005 Port start_i, input, 1: start schedule generation; sampled only in IDLE or ERROR.
REQ-006 Port op_i, input, 2: cipher operation, latched at start and forwarded to the engine.
REQ-007 Port key_i, input, 128: initial key, latched at start.
REQ-008 Port busy_o, output, 1: high in CLEAR or REQ.
REQ-009 Port done_o, output, 1: one-cycle pulse when the last round key is stored.
REQ-010 Port keys_valid_o, output, 1: key buffer holds a complete schedule.
REQ-011 Port err_o, output, 1: engine timeout occurred; high while in ERROR.
REQ-012 Port eng_clear_o, output, 1: engine clear strobe.
REQ-013 Port eng_en_o, output, 1: engine enable or request valid.
REQ-014 Port eng_op_o, output, 2: latched op.
REQ-015 Port eng_round_o, output, 4: current round index.
REQ-016 Port eng_key_o, output, 128: key presented to the engine for the current round.
REQ-017 Port eng_req_i, input, 1: engine output valid (engine out_req).
REQ-018 Port eng_ack_o, output, 1: acknowledge to the engine (engine out_ack).
REQ-019 Port eng_key_i, input, 128: engine output key.
REQ-020 Port rd_idx_i, input, 4: round-key read index.
REQ-021 Port rd_data_o, output, 128: round key at the registered rd_idx_i.
REQ-022 Port rd_err_o, output, 1: registered flag, rd_idx_i > NumRounds.

Function
REQ-023 FSM states: IDLE, CLEAR, REQ, DONE, ERROR.
REQ-024 IDLE or ERROR with start_i=1:
- rk[0] takes key_i; op is latched.
- round=0; timeout counter=0.
- keys_valid_o=0; err_o clears.
- Next state CLEAR.
REQ-025 CLEAR: eng_clear_o=1 for exactly one cycle, then REQ.
REQ-026 REQ drives eng_en_o=1, eng_round_o=round, eng_key_o=rk[round]; all other states drive eng_en_o=0.
REQ-027 eng_ack_o shall equal state==REQ AND eng_req_i, combinationally, in the same cycle.
REQ-028 On an eng_req_i=1 cycle in REQ:
- rk[round+1] takes eng_key_i; timeout counter resets.
- If round+1==NumRounds, go to DONE.
- Otherwise round increments and the state stays REQ.
REQ-029 On an eng_req_i=0 cycle in REQ, the timeout counter increments; when it reaches TimeoutCycles, go to ERROR with all engine outputs deasserted.
REQ-030 DONE: done_o=1 for one cycle, keys_valid_o set, next state IDLE.
REQ-031 ERROR: err_o=1, held until start_i or reset; keys_valid_o=0.
REQ-032 start_i shall be ignored in CLEAR, REQ and DONE.
REQ-033 An engine response arriving in the final allowed cycle shall be accepted; the timeout applies only when the counter reaches TimeoutCycles with no response.
REQ-034 The read port is registered, 1-cycle latency.
- rd_data_o = rk[rd_idx_i] if rd_idx_i <= NumRounds, else 0 with rd_err_o=1.
- Reads are allowed in any state; entries written in the current cycle are visible the next cycle.
REQ-035 The key buffer has NumRounds+1 entries of 128 bits and is not cleared on start; only keys_valid_o qualifies its contents.

Reset
REQ-036 rst_ni=0 shall asynchronously force:
- State IDLE; round=0; timeout counter=0.
- busy_o, done_o, keys_valid_o, err_o, eng_clear_o, eng_en_o, eng_ack_o, rd_err_o = 0.
- eng_op_o=0, eng_round_o=0, eng_key_o=0, rd_data_o=0, all rk entries=0.
REQ-037 Reset asserted mid-schedule shall abort with no done_o pulse; after release the block is in IDLE with keys_valid_o=0.

Verification
REQ-038 FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, behavioural engine responding 1 cycle after eng_en_o -> 10 acks, done_o one pulse, rd_idx_i=10 yields d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-039 Engine holds eng_req_i=0 for 15 cycles in round 3 -> err_o=1, eng_en_o=0, keys_valid_o=0; a new start_i clears err_o and enters CLEAR.
REQ-040 start_i pulsed during REQ round 5 -> ignored; round sequence continues 5..9 unchanged.
REQ-041 rst_ni low at round 7 -> all outputs 0 immediately; a later start completes a full schedule correctly.
REQ-042 rd_idx_i=11 -> rd_data_o=0, rd_err_o=1 next cycle; rd_idx_i=0 -> rd_data_o=key_i.
REQ-043 Engine asserts eng_req_i on the 14th waiting cycle -> accepted, no error.
